// File: rtl/matrix_result_serializer.sv
// Captures 4x4 result frames into a two-entry ping-pong buffer and streams the
// elements out one per valid/ready handshake in row-major or column-major order.
module matrix_result_serializer #(
    parameter int ELEM_W = 32,
    parameter int DIM    = 4,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ELEM_W*DIM*DIM-1:0]   in_result,
    input  logic                        in_col_major,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ELEM_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_index,
    output logic                        out_last,
    output logic [CNT_W-1:0]            frame_count
);

    localparam int N_ELEM  = DIM * DIM;
    localparam int FRAME_W = ELEM_W * N_ELEM;
    localparam int HALF_W  = IDX_W / 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    logic [1:0]         full_reg;
    logic [1:0]         order_reg;
    logic [FRAME_W-1:0] frame_reg [2];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               accept;
    logic               fire;
    logic               drain_last;
    logic [IDX_W-1:0]   elem_k;
    logic [FRAME_W-1:0] sel_frame;
    logic [ELEM_W-1:0]  elems [N_ELEM];

    assign in_ready    = ~(full_reg[0] & full_reg[1]);
    assign out_valid   = full_reg[rd_ptr_reg];
    assign accept      = in_valid & in_ready;
    assign fire        = out_valid & out_ready;
    assign drain_last  = fire & (idx_reg == LAST_IDX);
    assign frame_count = count_reg;

    // Control state; capture and drain never touch the same entry in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_reg   <= 2'b00;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            idx_reg    <= '0;
            count_reg  <= '0;
        end else begin
            if (accept) begin
                full_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (drain_last) begin
                full_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg           <= ~rd_ptr_reg;
                idx_reg              <= '0;
                count_reg            <= count_reg + CNT_W'(1);
            end else if (fire) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            frame_reg[wr_ptr_reg] <= in_result;
            order_reg[wr_ptr_reg] <= in_col_major;
        end
    end

    assign sel_frame = frame_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < N_ELEM; gi++) begin : g_elem
            assign elems[gi] = sel_frame[gi*ELEM_W +: ELEM_W];
        end
    endgenerate

    // Column-major swaps the row and column halves of the counter.
    assign elem_k = order_reg[rd_ptr_reg] ? {idx_reg[HALF_W-1:0], idx_reg[IDX_W-1:HALF_W]}
                                          : idx_reg;

    always_comb begin
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_data  = elems[elem_k];
            out_index = elem_k;
            out_last  = (idx_reg == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Scoreboard bench: frames push expected elements on acceptance, a negedge
// monitor pops and compares every output handshake and checks stall stability.
module tb_matrix_result_serializer;

    localparam int ELEM_W = 32;
    localparam int DIM    = 4;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 8;
    localparam int N      = DIM * DIM;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [ELEM_W*N-1:0]  in_result;
    logic                 in_col_major;
    logic                 out_valid;
    logic                 out_ready;
    logic [ELEM_W-1:0]    out_data;
    logic [IDX_W-1:0]     out_index;
    logic                 out_last;
    logic [CNT_W-1:0]     frame_count;

    typedef struct packed {
        logic [ELEM_W-1:0] data;
        logic [IDX_W-1:0]  index;
        logic              last;
    } exp_t;

    exp_t sb[$];
    int   assertions = 0;
    int   failures   = 0;
    int   popped     = 0;

    matrix_result_serializer #(
        .ELEM_W(ELEM_W), .DIM(DIM), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_col_major(in_col_major),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each accepted element and hold-stability during stalls.
    initial begin
        logic stalled;
        exp_t held;
        exp_t e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_stable", 64'({out_data, out_index, out_last}), 64'(held));
                end
                if (out_valid) begin
                    held    = {out_data, out_index, out_last};
                    stalled = !out_ready;
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_output", 64'(out_valid), 64'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("element", 64'({out_data, out_index, out_last}), 64'(e));
                            popped++;
                        end
                    end
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    task automatic push_frame(input logic [31:0] base, input logic col);
        exp_t e;
        int   k;
        for (int i = 0; i < N; i++) begin
            k       = col ? (i % DIM) * DIM + (i / DIM) : i;
            e.data  = base + 32'(k);
            e.index = IDX_W'(k);
            e.last  = (i == N - 1);
            sb.push_back(e);
        end
    endtask

    task automatic load_frame(input logic [31:0] base, input logic col);
        for (int k = 0; k < N; k++) in_result[k*ELEM_W +: ELEM_W] = base + 32'(k);
        in_col_major = col;
    endtask

    // Holds in_valid until accepted; returns the number of edges taken.
    task automatic send_frame(input logic [31:0] base, input logic col, output int waited);
        logic acc;
        load_frame(base, col);
        in_valid = 1'b1;
        waited   = 0;
        acc      = 1'b0;
        while (!acc && waited < 200) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (acc) push_frame(base, col);
        else chk("accept_timeout", 64'(waited), 64'd0);
    endtask

    task automatic wait_drain(input int bound);
        int c;
        c = 0;
        while (sb.size() != 0 && c < bound) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        int         c;
        int         p0;
        logic [3:0] pat;

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_result    = '0;
        in_col_major = 1'b0;
        out_ready    = 1'b0;
        pat          = 4'b1001;

        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_frame_count", 64'(frame_count), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Row-major drain with first-element latency check
        out_ready = 1'b1;
        send_frame(32'h1000_0000, 1'b0, w);
        chk("latency_valid", 64'(out_valid), 64'd1);
        wait_drain(50);
        chk("frame_count_row", 64'(frame_count), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_out_index", 64'({out_data, out_index, out_last}), 64'd0);

        // Column-major drain
        send_frame(32'h1000_0000, 1'b1, w);
        wait_drain(50);
        chk("frame_count_col", 64'(frame_count), 64'd2);

        // Backpressure pattern 1,0,0,1
        send_frame(32'h3000_0000, 1'b0, w);
        c = 0;
        while (sb.size() != 0 && c < 200) begin
            out_ready = pat[c % 4];
            @(posedge clk);
            #1;
            c++;
        end
        chk("bp_drain_timeout", 64'(sb.size()), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("frame_count_bp", 64'(frame_count), 64'd3);

        // Ping-pong full
        out_ready = 1'b0;
        send_frame(32'h4000_0000, 1'b0, w);
        chk("pp_first_accept", 64'(w), 64'd1);
        send_frame(32'h5000_0000, 1'b1, w);
        chk("pp_second_accept", 64'(w), 64'd1);
        load_frame(32'h6000_0000, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("pp_in_ready_full", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 2 * N; i++) begin
                    chk("pp_no_bubble", 64'(out_valid), 64'd1);
                    @(posedge clk);
                    #1;
                end
            end
            begin
                int wc;
                send_frame(32'h6000_0000, 1'b0, wc);
                chk("pp_third_accept_edge", 64'(wc), 64'd17);
            end
        join
        wait_drain(100);
        chk("frame_count_pp", 64'(frame_count), 64'd6);

        // Reset mid-frame after 7 elements
        p0 = popped;
        send_frame(32'h7000_0000, 1'b0, w);
        c = 0;
        while (popped < p0 + 7 && c < 100) begin
            @(posedge clk);
            c++;
        end
        chk("mid_progress", 64'(popped - p0), 64'd7);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
        chk("mid_reset_in_ready", 64'(in_ready), 64'd1);
        chk("mid_reset_frame_count", 64'(frame_count), 64'd0);
        chk("mid_reset_outputs", 64'({out_data, out_index, out_last}), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_reset_quiet", 64'(out_valid), 64'd0);
        end
        send_frame(32'h8000_0000, 1'b1, w);
        wait_drain(50);
        chk("frame_count_after_reset", 64'(frame_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Downstream consumer of the parallel adder/subtractor's 512-bit `result` bus.
- The bus holds a 4x4 matrix of 32-bit elements. Element k (row r, col c, k = r*4 + c) sits at bits [32k+31:32k].
- The block captures whole result frames into a 2-entry ping-pong buffer and streams the elements out one per handshake, in row-major or column-major order.
- Output is a valid/ready stream to the writeback/memory stage.

Parameters:
- ELEM_W, 32, width of one result element in bits.
- DIM, 4, matrix dimension. N_ELEM = DIM*DIM. DIM must be a power of two and at least 2.
- IDX_W, 4, equals log2(N_ELEM); index/counter width.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  `in_result` holds a complete frame.
- in_ready  output  1  a buffer entry is free; frame accepted when in_valid & in_ready at the clk edge.
- in_result  input  ELEM_W*N_ELEM  frame from the adder/subtractor `result`.
- in_col_major  input  1  order for this frame (0 = row-major, 1 = column-major); captured with the frame.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  downstream accepts the element this cycle.
- out_data  output  ELEM_W  current element.
- out_index  output  IDX_W  matrix position k of out_data.
- out_last  output  1  high on the final element of a frame.
- frame_count  output  CNT_W  number of fully drained frames; wraps from 2^CNT_W-1 to 0.

Behaviour:
- **Reset (asynchronous, any time, including mid-frame):**
  - Both buffer entries empty; wr_ptr = rd_ptr = 0; element counter idx = 0.
  - Outputs: out_valid = 0, out_last = 0, out_index = 0, out_data = 0, frame_count = 0, in_ready = 1.
  - Partially drained frames are discarded; no element is emitted after reset deasserts until a new frame is accepted.
- **State:**
  - Per entry: full flag, ELEM_W*N_ELEM data register, order bit.
  - Plus wr_ptr, rd_ptr and idx (IDX_W bits).
- **in_ready:**
  - in_ready = !(full[0] & full[1]), decoded from registered state only. There is no combinational path from out_ready or in_valid.
  - When both entries are full, in_ready is 0 even in a cycle where the final element is being accepted.
- **Capture:**
  - On in_valid & in_ready, at the edge: entry[wr_ptr] ← {in_result, in_col_major}, full[wr_ptr] ← 1, wr_ptr toggles.
  - in_result is not sampled at any other time.
- **Output:**
  - out_valid = full[rd_ptr].
  - Latency: a frame accepted at edge N into an empty block gives out_valid = 1 with element 0 of that frame during the cycle after edge N.
- **Element mapping (row-major / column-major):**
  - Row-major: k = idx.
  - Column-major: k = (idx mod DIM)*DIM + (idx / DIM).
  - out_index = k; out_data = entry[rd_ptr] bits [ELEM_W*k +: ELEM_W]; out_last = (idx == N_ELEM-1).
  - When out_valid = 0: out_data, out_index and out_last are forced to 0.
- **Stability:** while out_valid & !out_ready, out_data, out_index and out_last hold stable.
- **Element handshake:** on out_valid & out_ready with idx < N_ELEM-1, idx increments.
- **Last-element handshake (idx = N_ELEM-1):**
  - full[rd_ptr] ← 0, rd_ptr toggles, idx ← 0, frame_count increments (wraps).
  - If the other entry is full, out_valid stays 1 and element 0 of the next frame appears the next cycle, with no bubble.
- **Simultaneous events:**
  - Capture and last-element drain in the same edge (only possible with exactly one entry full): both take effect.
  - In that case the draining entry empties and the other entry fills, so one frame remains.
  - Capture into an empty block while draining nothing: out_valid rises next cycle.
- **Arithmetic:** element values are passed through unmodified; no sign handling.
- **Throughput:** sustained one element per cycle with out_ready held high. A 16-element frame drains in 16 cycles.

Test Plan:
- **Reset values:** assert reset asynchronously between clock edges → out_valid = 0, in_ready = 1, frame_count = 0 immediately, before the next edge.
- **Row-major drain:** one frame with element k = 32'h1000_0000 + k, row-major, out_ready = 1 → out_valid the cycle after accept.
  - out_data 0x10000000..0x1000000F, out_index 0..15, out_last only at index 15, frame_count = 1.
- **Column-major drain:** same frame with in_col_major = 1 → out_index sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15, with out_data = 0x10000000 + out_index.
- **Backpressure:** out_ready toggled 1,0,0,1 repeatedly → data held stable during stalls, no element skipped or duplicated, all 16 delivered.
- **Ping-pong full:** present three frames back-to-back with out_ready = 0 → first two accepted, in_ready = 0 for the third.
  - Then out_ready = 1: 32 consecutive valid elements with no bubble between frames; third frame accepted after the first frame's out_last.
- **Reset mid-frame:** reset after 7 of 16 elements of frame A, then send frame B → no remaining A elements; B emitted from index 0; frame_count = 1 at the end.
